// File: rtl/digest_target_check.sv
`default_nettype none
// ============================================================================
// digest_target_check: polls sha256 STATUS, reads DIGEST0..7, compares the hash to a target.
// Rev 1.0
// ============================================================================
module digest_target_check #(
   parameter int BYTE_SWAP    = 1,
   parameter int POLL_TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [31:0]  nonce_i,
   input  logic [255:0] target_i,
   output logic         sha_cs,
   output logic         sha_we,
   output logic [7:0]   sha_address,
   input  logic [31:0]  sha_read_data,
   output logic         busy,
   output logic         done,
   output logic         hit,
   output logic         timeout,
   output logic [31:0]  hit_nonce,
   output logic [255:0] digest_o
);

   localparam int            PW            = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
   localparam logic [PW-1:0] C_POLL_LAST   = PW'(POLL_TIMEOUT - 1);
   localparam logic [7:0]    C_ADDR_STATUS = 8'h09;
   localparam logic [4:0]    C_DIGEST_BASE = 5'b00100;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_POLL_REQ = 3'd1,
      S_POLL_CHK = 3'd2,
      S_RD_REQ   = 3'd3,
      S_RD_CAP   = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      CMP_EQ = 2'd0,
      CMP_LT = 2'd1,
      CMP_GT = 2'd2
   } cmp_t;

   state_t         r_state;
   cmp_t           r_cmp;
   logic [PW-1:0]  r_poll_cnt;
   logic [2:0]     r_idx;
   logic [31:0]    r_nonce;
   logic [255:0]   r_hash;
   logic           r_cs;
   logic [7:0]     r_addr;
   logic           r_busy;
   logic           r_done;
   logic           r_hit;
   logic           r_timeout;
   logic [31:0]    r_hit_nonce;
   logic [255:0]   r_digest;

   logic [31:0]    w_word;
   logic [255:0]   w_tgt_shift;
   logic [31:0]    w_tgt_word;
   logic [2:0]     w_idx_inc;
   logic           w_status_valid;
   cmp_t           w_cmp_nxt;

   // Bitcoin order walks the digest words backwards so the hash is built MS word first.
   function automatic logic [7:0] digest_addr(input logic [2:0] idx);
      return (BYTE_SWAP != 0) ? {C_DIGEST_BASE, ~idx} : {C_DIGEST_BASE, idx};
   endfunction

   generate
      if (BYTE_SWAP != 0) begin : g_swap
         assign w_word = {sha_read_data[7:0], sha_read_data[15:8],
                          sha_read_data[23:16], sha_read_data[31:24]};
      end else begin : g_noswap
         assign w_word = sha_read_data;
      end
   endgenerate

   assign w_tgt_shift    = target_i << {r_idx, 5'd0};
   assign w_tgt_word     = w_tgt_shift[255:224];
   assign w_idx_inc      = r_idx + 3'd1;
   assign w_status_valid = sha_read_data[1];

   // Magnitude is decided by the first unequal word, most significant first.
   always_comb begin
      w_cmp_nxt = r_cmp;
      if (r_cmp == CMP_EQ) begin
         if (w_word < w_tgt_word) begin
            w_cmp_nxt = CMP_LT;
         end else if (w_word > w_tgt_word) begin
            w_cmp_nxt = CMP_GT;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cmp       <= CMP_EQ;
         r_poll_cnt  <= '0;
         r_idx       <= '0;
         r_nonce     <= '0;
         r_hash      <= '0;
         r_cs        <= 1'b0;
         r_addr      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_hit       <= 1'b0;
         r_timeout   <= 1'b0;
         r_hit_nonce <= '0;
         r_digest    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_nonce    <= nonce_i;
                  r_hit      <= 1'b0;
                  r_timeout  <= 1'b0;
                  r_poll_cnt <= '0;
                  r_idx      <= '0;
                  r_cmp      <= CMP_EQ;
                  r_hash     <= '0;
                  r_busy     <= 1'b1;
                  r_cs       <= 1'b1;
                  r_addr     <= C_ADDR_STATUS;
                  r_state    <= S_POLL_REQ;
               end
            end
            S_POLL_REQ: begin
               r_state <= S_POLL_CHK;
            end
            S_POLL_CHK: begin
               if (w_status_valid) begin
                  r_addr  <= digest_addr(r_idx);
                  r_state <= S_RD_REQ;
               end else if (r_poll_cnt == C_POLL_LAST) begin
                  r_cs        <= 1'b0;
                  r_timeout   <= 1'b1;
                  r_hit       <= 1'b0;
                  r_done      <= 1'b1;
                  r_digest    <= '0;
                  r_hit_nonce <= r_nonce;
                  r_state     <= S_DONE;
               end else begin
                  r_poll_cnt <= r_poll_cnt + 1'b1;
                  r_state    <= S_POLL_REQ;
               end
            end
            S_RD_REQ: begin
               r_state <= S_RD_CAP;
            end
            S_RD_CAP: begin
               r_hash <= {r_hash[223:0], w_word};
               r_cmp  <= w_cmp_nxt;
               if (r_idx == 3'd7) begin
                  r_cs        <= 1'b0;
                  r_done      <= 1'b1;
                  r_hit       <= (w_cmp_nxt != CMP_GT) && !r_timeout;
                  r_digest    <= {r_hash[223:0], w_word};
                  r_hit_nonce <= r_nonce;
                  r_state     <= S_DONE;
               end else begin
                  r_idx   <= w_idx_inc;
                  r_addr  <= digest_addr(w_idx_inc);
                  r_state <= S_RD_REQ;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_cs    <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign sha_cs      = r_cs;
   assign sha_we      = 1'b0;
   assign sha_address = r_addr;
   assign busy        = r_busy;
   assign done        = r_done;
   assign hit         = r_hit;
   assign timeout     = r_timeout;
   assign hit_nonce   = r_hit_nonce;
   assign digest_o    = r_digest;

endmodule
`default_nettype wire

// File: tb/tb_digest_target_check.sv
`default_nettype none
// ============================================================================
// tb_digest_target_check: two instances (plain and Bitcoin byte order) against a sha256 register model.
// Rev 1.0
// ============================================================================
module tb_digest_target_check;

   localparam int PT = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]         start;
   logic [1:0][31:0]   nonce_in;
   logic [1:0][255:0]  tgt;
   logic [1:0]         sha_cs, sha_we, busy, done, hit, tmo;
   logic [1:0][7:0]    sha_addr;
   logic [1:0][31:0]   sha_rd;
   logic [1:0][31:0]   hnonce;
   logic [1:0][255:0]  dig;

   digest_target_check #(.BYTE_SWAP(0), .POLL_TIMEOUT(PT)) u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .nonce_i(nonce_in[0]), .target_i(tgt[0]),
      .sha_cs(sha_cs[0]), .sha_we(sha_we[0]), .sha_address(sha_addr[0]),
      .sha_read_data(sha_rd[0]), .busy(busy[0]), .done(done[0]), .hit(hit[0]),
      .timeout(tmo[0]), .hit_nonce(hnonce[0]), .digest_o(dig[0]));

   digest_target_check #(.BYTE_SWAP(1), .POLL_TIMEOUT(PT)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .nonce_i(nonce_in[1]), .target_i(tgt[1]),
      .sha_cs(sha_cs[1]), .sha_we(sha_we[1]), .sha_address(sha_addr[1]),
      .sha_read_data(sha_rd[1]), .busy(busy[1]), .done(done[1]), .hit(hit[1]),
      .timeout(tmo[1]), .hit_nonce(hnonce[1]), .digest_o(dig[1]));

   // sha256 register file model: STATUS goes valid from poll number valid_at (0 = never).
   logic [31:0] dreg [2][8];
   int          valid_at [2];
   int          poll_base [2];
   int          a9_edges [2];
   int          rcnt [2];
   logic [7:0]  rlast [2];
   logic [7:0]  rlog [2][1024];

   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (sha_cs[g]) begin
            if (sha_addr[g] == 8'h09) begin
               sha_rd[g]   <= (valid_at[g] > 0 &&
                               ((a9_edges[g] - poll_base[g]) / 2 + 1) >= valid_at[g]) ? 32'h2 : 32'h0;
               a9_edges[g] <= a9_edges[g] + 1;
               rlast[g]    <= 8'h00;
            end else if (sha_addr[g][7:3] == 5'b00100) begin
               sha_rd[g] <= dreg[g][sha_addr[g][2:0]];
               if (sha_addr[g] != rlast[g] && rcnt[g] < 1024) begin
                  rlog[g][rcnt[g]] <= sha_addr[g];
                  rcnt[g]          <= rcnt[g] + 1;
               end
               rlast[g] <= sha_addr[g];
            end else begin
               sha_rd[g] <= 32'hDEAD_BEEF;
            end
         end
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Hash as defined: digest words concatenated D0 first, fully byte-reversed in Bitcoin order.
   function automatic logic [255:0] ref_hash(input int g);
      logic [255:0] cat, h;
      for (int i = 0; i < 8; i++) cat[255 - 32*i -: 32] = dreg[g][i];
      if (g == 1) begin
         for (int b = 0; b < 32; b++) h[8*b +: 8] = cat[255 - 8*b -: 8];
      end else begin
         h = cat;
      end
      return h;
   endfunction

   task automatic run_check(input int g, input logic [31:0] n, input logic [255:0] t,
                            input int vat, input string tag);
      int           lat, rb, exp_lat, exp_polls;
      logic         exp_to, exp_hit;
      logic [255:0] exp_h;
      logic [63:0]  obs_rd, exp_rd;
      exp_to    = (vat < 1) || (vat > PT);
      exp_lat   = exp_to ? 2*PT + 1 : 19 + 2*(vat - 1);
      exp_polls = exp_to ? PT : vat;
      exp_h     = exp_to ? '0 : ref_hash(g);
      exp_hit   = !exp_to && (exp_h <= t);
      @(negedge clk);
      valid_at[g]  = vat;
      poll_base[g] = a9_edges[g];
      rb           = rcnt[g];
      tgt[g]       = t;
      nonce_in[g]  = n;
      start[g]     = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
      lat      = 1;
      while (!done[g] && lat < 80) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"},    256'(lat), 256'(exp_lat));
      chk({tag, "_busy"},   256'(busy[g]), 256'(1));
      chk({tag, "_hit"},    256'(hit[g]), 256'(exp_hit));
      chk({tag, "_tmo"},    256'(tmo[g]), 256'(exp_to));
      chk({tag, "_digest"}, dig[g], exp_h);
      chk({tag, "_nonce"},  256'(hnonce[g]), 256'(n));
      chk({tag, "_polls"},  256'((a9_edges[g] - poll_base[g]) / 2), 256'(exp_polls));
      chk({tag, "_nreads"}, 256'(rcnt[g] - rb), 256'(exp_to ? 0 : 8));
      if (!exp_to) begin
         for (int i = 0; i < 8; i++) begin
            obs_rd[63 - 8*i -: 8] = rlog[g][(rb + i) % 1024];
            exp_rd[63 - 8*i -: 8] = (g == 0) ? 8'(8'h20 + i) : 8'(8'h27 - i);
         end
         chk({tag, "_rdorder"}, 256'(obs_rd), 256'(exp_rd));
      end
      @(negedge clk);
      chk({tag, "_after"}, 256'({done[g], busy[g], sha_cs[g], sha_we[g], hit[g]}),
          256'({4'b0000, exp_hit}));
   endtask

   logic [255:0] h, t, one;
   int           g, lat, ndone;

   initial begin
      rst      = 1'b1;
      start    = '0;
      nonce_in = '0;
      tgt      = '0;
      for (int k = 0; k < 2; k++) begin
         valid_at[k]  = 0;
         poll_base[k] = 0;
         for (int i = 0; i < 8; i++) dreg[k][i] = 32'h0;
      end
      repeat (3) @(negedge clk);
      chk("reset_ctl", 256'({busy, done, hit, tmo, sha_cs, sha_we}), 256'(0));
      chk("reset_addr", 256'(sha_addr), 256'(0));
      chk("reset_nonce", 256'(hnonce), 256'(0));
      chk("reset_digest", dig[0] | dig[1], 256'(0));
      rst = 1'b0;

      // Plain order, counting words, target all ones.
      for (int i = 0; i < 8; i++) dreg[0][i] = 32'(i);
      run_check(0, 32'h1234_5678, '1, 1, "t1");
      chk("t1_digest_const", dig[0], {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7});

      // Word 0 above target word 0 -> miss.
      dreg[0][0] = 32'h1;
      run_check(0, 32'h0000_0002, {32'h0, {224{1'b1}}}, 1, "t2");

      // Exact equality is a hit.
      run_check(0, 32'h0000_0003, ref_hash(0), 1, "t3");

      // Bitcoin byte order.
      for (int i = 0; i < 8; i++) dreg[1][i] = 32'h0;
      dreg[1][7] = 32'h1122_3344;
      run_check(1, 32'hCAFE_0004, '1, 1, "t4");
      chk("t4_msword", 256'(dig[1][255:224]), 256'(32'h4433_2211));

      // STATUS never valid, then valid on the third poll.
      run_check(0, 32'h0000_0005, '1, 0, "t5_to");
      run_check(0, 32'h0000_0006, '1, 3, "t5_p3");

      // Randomized digests and targets against the reference model.
      one = 256'd1;
      for (int k = 0; k < 10; k++) begin
         g = int'($urandom_range(0, 1));
         for (int i = 0; i < 8; i++) dreg[g][i] = $urandom;
         h = ref_hash(g);
         case ($urandom_range(0, 2))
            0: for (int w = 0; w < 8; w++) t[32*w +: 32] = $urandom;
            1: t = h;
            default: t = h ^ (one << $urandom_range(0, 255));
         endcase
         run_check(g, $urandom, t, int'($urandom_range(1, PT + 1)), "rnd");
      end

      // start during RD_CAP idx 3 must not restart or relatch the nonce.
      for (int i = 0; i < 8; i++) dreg[0][i] = 32'h1000_0000 + 32'(i);
      @(negedge clk);
      valid_at[0]  = 1;
      poll_base[0] = a9_edges[0];
      tgt[0]       = '1;
      nonce_in[0]  = 32'hAAAA_0001;
      start[0]     = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      lat      = 1;
      while (sha_addr[0] != 8'h23 && lat < 80) begin
         @(negedge clk);
         lat++;
      end
      @(negedge clk);
      lat++;
      start[0]    = 1'b1;
      nonce_in[0] = 32'hBBBB_0002;
      @(negedge clk);
      lat++;
      start[0] = 1'b0;
      while (!done[0] && lat < 80) begin
         @(negedge clk);
         lat++;
      end
      chk("t6_ign_lat", 256'(lat), 256'(19));
      chk("t6_ign_nonce", 256'(hnonce[0]), 256'(32'hAAAA_0001));
      chk("t6_ign_digest", dig[0], ref_hash(0));

      // Reset during the idx 5 read aborts silently.
      repeat (2) @(negedge clk);
      nonce_in[0] = 32'hCCCC_0003;
      start[0]    = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      lat      = 1;
      while (sha_addr[0] != 8'h25 && lat < 80) begin
         @(negedge clk);
         lat++;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_rst_busy_cs", 256'({busy[0], sha_cs[0], done[0]}), 256'(0));
      @(negedge clk);
      rst   = 1'b0;
      ndone = 0;
      repeat (30) begin
         @(negedge clk);
         if (done[0] || busy[0]) ndone++;
      end
      chk("t6_rst_quiet", 256'(ndone), 256'(0));
      chk("t6_rst_nonce", 256'(hnonce[0]), 256'(0));

      run_check(0, 32'hDDDD_0004, '1, 1, "t6_clean");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
